// File: rtl/modn_sched_if.sv
// modn_sched_if: requester-side bus of the shared mod-N scheduler.
// Optional feature macro: MODN_SCHED_PAUSE_EN adds the pause signal.
//   req/req_mod/req_rpt : per-requester request, modulus and repeat count
//   abort               : terminate the running job
//   pause               : freeze the counter (MODN_SCHED_PAUSE_EN only)
//   gnt/busy            : one-hot owner, job in progress
//   counter/wrap        : shared count and last-count-of-period flag
//   done                : one-cycle completion pulse per requester
interface modn_sched_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned RPT_W = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_mod;
    logic [NREQ*RPT_W-1:0] req_rpt;
    logic                  abort;
`ifdef MODN_SCHED_PAUSE_EN
    logic                  pause;
`endif
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [WIDTH-1:0]      counter;
    logic                  wrap;
    logic [NREQ-1:0]       done;

`ifdef MODN_SCHED_PAUSE_EN
    modport master (output req, req_mod, req_rpt, abort, pause,
                    input  gnt, busy, counter, wrap, done);
    modport slave  (input  req, req_mod, req_rpt, abort, pause,
                    output gnt, busy, counter, wrap, done);
`else
    modport master (output req, req_mod, req_rpt, abort,
                    input  gnt, busy, counter, wrap, done);
    modport slave  (input  req, req_mod, req_rpt, abort,
                    output gnt, busy, counter, wrap, done);
`endif
endinterface

// File: rtl/modn_sched.sv
// modn_sched: round-robin scheduler sharing one mod-N counter among NREQ
// requesters. A granted job counts 0..mod for (rpt+1) periods, flags each
// wrap, then pulses done to its owner.
// Optional feature macro: MODN_SCHED_PAUSE_EN (pause input freezes the count).
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : modn_sched_if slave modport (requests in, grant/count/status out)
module modn_sched #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned RPT_W = 8
) (
    input  logic          clk,
    input  logic          resetn,
    modn_sched_if.slave   bus
);
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state, w_state;
    logic [NREQ-1:0]    r_gnt, w_gnt;
    logic [NREQ-1:0]    r_done, w_done;
    logic [WIDTH-1:0]   r_counter, w_counter;
    logic [WIDTH-1:0]   r_mod_q, w_mod_q;
    logic [RPT_W-1:0]   r_rpt_q, w_rpt_q;
    logic [IDX_W-1:0]   r_last, w_last;
    logic [IDX_W-1:0]   r_owner, w_owner;
    logic               r_wrap, w_wrap;
    logic               r_busy;

    logic               w_win_vld;
    logic [IDX_W-1:0]   w_win;
    logic               w_hold;

`ifdef MODN_SCHED_PAUSE_EN
    assign w_hold = bus.pause;
`else
    assign w_hold = 1'b0;
`endif

    // Round-robin pick: first requester found scanning from last+1 upward.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand      = '0;
        w_win_vld = 1'b0;
        w_win     = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDX_W'((32'(r_last) + i) % NREQ);
            if (!w_win_vld && bus.req[cand]) begin
                w_win_vld = 1'b1;
                w_win     = cand;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state   = r_state;
        w_gnt     = r_gnt;
        w_done    = '0;
        w_counter = r_counter;
        w_mod_q   = r_mod_q;
        w_rpt_q   = r_rpt_q;
        w_last    = r_last;
        w_owner   = r_owner;

        unique case (r_state)
            S_IDLE: begin
                w_gnt     = '0;
                w_counter = '0;
                if (w_win_vld) begin
                    w_state = S_RUN;
                    w_gnt   = NREQ'(1) << w_win;
                    w_owner = w_win;
                    w_mod_q = bus.req_mod[32'(w_win)*WIDTH +: WIDTH];
                    w_rpt_q = bus.req_rpt[32'(w_win)*RPT_W +: RPT_W];
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_state   = S_IDLE;
                    w_gnt     = '0;
                    w_counter = '0;
                    w_last    = r_owner;
                end else if (w_hold) begin
                    w_counter = r_counter;
                end else if (r_counter != r_mod_q) begin
                    w_counter = r_counter + WIDTH'(1);
                end else begin
                    w_counter = '0;
                    if (r_rpt_q == '0) begin
                        w_state = S_DONE;
                        w_done  = r_gnt;
                    end else begin
                        w_rpt_q = r_rpt_q - RPT_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_state   = S_IDLE;
                w_gnt     = '0;
                w_counter = '0;
                w_last    = r_owner;
            end
            default: begin
                w_state   = S_IDLE;
                w_gnt     = '0;
                w_counter = '0;
            end
        endcase

        w_wrap = (w_state == S_RUN) && (w_counter == w_mod_q);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_done    <= '0;
            r_counter <= '0;
            r_mod_q   <= '0;
            r_rpt_q   <= '0;
            r_last    <= IDX_W'(NREQ - 1);
            r_owner   <= '0;
            r_wrap    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_gnt     <= w_gnt;
            r_done    <= w_done;
            r_counter <= w_counter;
            r_mod_q   <= w_mod_q;
            r_rpt_q   <= w_rpt_q;
            r_last    <= w_last;
            r_owner   <= w_owner;
            r_wrap    <= w_wrap;
            r_busy    <= |w_gnt;
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.busy    = r_busy;
    assign bus.counter = r_counter;
    assign bus.done    = r_done;
`ifdef MODN_SCHED_PAUSE_EN
    // A held count must not report a wrap while frozen.
    assign bus.wrap    = r_wrap & ~bus.pause;
`else
    assign bus.wrap    = r_wrap;
`endif

endmodule
